cim_temp_mem_arbiter: RTL and testbench
=======================================

Name: cim_temp_mem_arbiter

Overview:
- Downstream consumer of the CiM memory-access interface (one-hot read/write request sources BUS_FSM, LOGIC_FSM, MAC; per-source address table; per-source write data).
- Arbitrates those requests onto the single-port temporary-result storage, which it contains.
- Returns read data through a fixed-latency pipeline, tagged with the one-hot source that issued the read.
- Flags out-of-range addresses and counts arbitration conflicts.

Parameters:
- N_SRC, 3, number of requesters; index 0=BUS_FSM, 1=LOGIC_FSM, 2=MAC.
- DEPTH, TEMP_RES_STORAGE_SIZE_CIM, words of temporary storage.
- ADDR_W, $clog2(TEMP_RES_STORAGE_SIZE_CIM), address width.
- DATA_W, N_STORAGE, word width.
- RD_LAT, 2, read latency in cycles from grant to read_valid; legal values 1..4.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset.
- read_req_src  in  N_SRC  per-source read request, level; held until granted.
- write_req_src  in  N_SRC  per-source write request, level; held until granted.
- addr_table  in  N_SRC*ADDR_W  per-source address; source i occupies bits [i*ADDR_W +: ADDR_W].
- write_data  in  N_SRC*DATA_W  per-source write data, same packing as addr_table.
- grant  out  N_SRC  one-hot (or zero); marks the source serviced this cycle, combinational from the requests.
- read_data  out  DATA_W  registered read data.
- read_valid  out  N_SRC  one-hot pulse: read_data is valid for that source this cycle.
- addr_err  out  1  one-cycle pulse, the cycle after a granted access with addr >= DEPTH.
- conflict_cnt  out  8  saturating count of cycles in which a requesting source was not granted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- While rst=1 at a rising edge:
  - grant=0, read_valid=0, read_data=0, addr_err=0, conflict_cnt=0.
  - The read pipeline is flushed, so reads in flight at reset never produce read_valid.
  - Storage contents are not cleared.
  - grant is forced to 0 while rst=1.
- Active source: source i is active if read_req_src[i] | write_req_src[i].
- Fixed priority: MAC (2) > LOGIC_FSM (1) > BUS_FSM (0). grant = one-hot of the highest-priority active source, or 0 if none is active.
- Exactly one access per cycle. The granted source performs:
  - a write if its write_req_src bit is set;
  - otherwise a read.
  - If one source asserts both read and write, the write wins. The read is not performed and must be re-requested.
- Write: mem[addr] <= data at the edge ending the grant cycle. A read of the same address granted in the next cycle returns the new value.
- Read: the address is captured at the grant edge.
  - read_data and read_valid[src] appear exactly RD_LAT cycles after the grant cycle.
  - Back-to-back reads from any sources are fully pipelined: one read per cycle, results returned in order.
- A write granted while earlier reads are in flight does not alter those reads. Each read returns memory contents as of its own grant edge.
- Out-of-range access (addr >= DEPTH) is still granted.
  - Write: dropped, memory unchanged.
  - Read: returns read_data=0 with normal read_valid timing.
  - Either case: addr_err pulses 1 cycle after the grant cycle.
- read_data holds its last value when read_valid=0. It is not zeroed between reads.
- conflict_cnt increments by 1 in any cycle where at least one active source is not granted. It increments by 1, not by the number of losers, and saturates at 255.
- Requesters that deassert before being granted: no access occurs. No internal request queue is kept.
- Starvation of low-priority sources is permitted by design. The upstream FSMs sequence their accesses so that it does not occur.

Test Plan:
- Reset, then MAC writes 0x1234 to addr 5 (held 1 cycle) -> grant=3'b100 that cycle. Next cycle BUS_FSM reads addr 5 -> grant=3'b001; read_valid=3'b001 with read_data=0x1234 exactly 2 cycles later.
- All three sources read addrs 1, 2, 3 (preloaded 0xA, 0xB, 0xC) in the same cycle, each held until granted:
  - grants are MAC, LOGIC, BUS in consecutive cycles;
  - read_valid 3'b100, 3'b010, 3'b001 in consecutive cycles with data 0xC, 0xB, 0xA;
  - conflict_cnt=2.
- LOGIC_FSM asserts read and write to addr 7 together with data 0x55 -> write performed, no read_valid; a subsequent read of addr 7 returns 0x55.
- BUS_FSM reads addr DEPTH -> addr_err=1 one cycle after grant; read_valid=3'b001 with read_data=0 at RD_LAT.
- Read granted, then rst=1 on the next cycle -> no read_valid ever appears; outputs 0; memory contents preserved (verified by a post-reset read).
- Hold MAC and BUS requests for 300 cycles -> conflict_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/cim_temp_mem_arbiter.sv
// Fixed-priority arbiter in front of the single-port temporary-result storage.
// Reads come back through an RD_LAT-deep pipeline tagged with the requesting source.
module cim_temp_mem_arbiter #(
    parameter int unsigned N_SRC  = 3,
    parameter int unsigned DEPTH  = 12,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          read_req_src,
    input  logic [N_SRC-1:0]          write_req_src,
    input  logic [N_SRC*ADDR_W-1:0]   addr_table,
    input  logic [N_SRC*DATA_W-1:0]   write_data,
    output logic [N_SRC-1:0]          grant,
    output logic [DATA_W-1:0]         read_data,
    output logic [N_SRC-1:0]          read_valid,
    output logic                      addr_err,
    output logic [7:0]                conflict_cnt
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [N_SRC-1:0]  active;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              is_write;
    logic              in_range;
    logic [N_SRC-1:0]  rd_grant;
    logic [DATA_W-1:0] rd_word;
    logic              conflict;

    logic [N_SRC-1:0]  vld_q [RD_LAT];
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic              addr_err_q;
    logic [7:0]        cnt_q;

    assign active = read_req_src | write_req_src;

    // Highest index wins: later loop iterations override earlier ones.
    always_comb begin
        grant     = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        is_write  = 1'b0;
        if (!rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (active[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                sel_addr  = addr_table[i*ADDR_W +: ADDR_W];
                sel_wdata = write_data[i*DATA_W +: DATA_W];
                is_write  = write_req_src[i];
            end
        end
    end

    assign in_range = {1'b0, sel_addr} < DEPTH_L;
    assign rd_grant = is_write ? '0 : grant;
    assign rd_word  = in_range ? mem[sel_addr] : '0;
    assign conflict = |(active & ~grant);

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (|grant && is_write && in_range) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Each stage only reloads data when a valid read passes through, so the
    // final stage holds the last returned word between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_q[k] <= '0;
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_grant;
            if (|rd_grant) begin
                dat_q[0] <= rd_word;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (|vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            addr_err_q <= |grant && !in_range;
            if (conflict && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign read_data    = dat_q[RD_LAT-1];
    assign read_valid   = vld_q[RD_LAT-1];
    assign addr_err     = addr_err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cim_temp_mem_arbiter.sv
// Directed plus random bench for cim_temp_mem_arbiter against a cycle-level
// transaction model (priority pick, memory array, queue of due read results).
module tb_cim_temp_mem_arbiter;

    localparam int N_SRC  = 3;
    localparam int DEPTH  = 12;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic                    clk;
    logic                    rst;
    logic [N_SRC-1:0]        rd;
    logic [N_SRC-1:0]        wr;
    logic [ADDR_W-1:0]       addr [N_SRC];
    logic [DATA_W-1:0]       wd   [N_SRC];
    logic [N_SRC*ADDR_W-1:0] addr_table;
    logic [N_SRC*DATA_W-1:0] write_data;
    logic [N_SRC-1:0]        grant;
    logic [DATA_W-1:0]       read_data;
    logic [N_SRC-1:0]        read_valid;
    logic                    addr_err;
    logic [7:0]              conflict_cnt;

    assign addr_table = {addr[2], addr[1], addr[0]};
    assign write_data = {wd[2], wd[1], wd[0]};

    cim_temp_mem_arbiter #(
        .N_SRC  (N_SRC),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .read_req_src  (rd),
        .write_req_src (wr),
        .addr_table    (addr_table),
        .write_data    (write_data),
        .grant         (grant),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .addr_err      (addr_err),
        .conflict_cnt  (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          src;
        logic [15:0] data;
    } rd_t;

    rd_t         pq [$];
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_last;
    int          m_cnt;
    logic        m_err;
    bit          known;
    int          cyc;
    int          last_g;
    int          n_chk;
    int          n_pass;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    // by what the spec says happens at the closing edge.
    task automatic tick();
        int          g;
        logic [2:0]  gm;
        logic [2:0]  ex_v;
        logic [15:0] ex_d;
        logic [3:0]  a;
        bit          in_rng;
        #1;
        g = -1;
        if (!rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (rd[i] || wr[i]) g = i;
            end
        end
        gm = (g < 0) ? 3'b000 : 3'(1 << g);
        chk("grant", {29'b0, grant}, {29'b0, gm});
        if (known) begin
            ex_v = 3'b000;
            ex_d = m_last;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                ex_v   = 3'(1 << pq[0].src);
                ex_d   = pq[0].data;
                m_last = ex_d;
                void'(pq.pop_front());
            end
            chk("read_valid", {29'b0, read_valid}, {29'b0, ex_v});
            chk("read_data", {16'b0, read_data}, {16'b0, ex_d});
            chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
            chk("conflict_cnt", {24'b0, conflict_cnt}, 32'(m_cnt));
        end
        if (rst) begin
            pq.delete();
            m_err  = 1'b0;
            m_cnt  = 0;
            m_last = 16'h0;
            known  = 1'b1;
        end else begin
            m_err = 1'b0;
            if (((rd | wr) & ~gm) != 3'b000 && m_cnt < 255) m_cnt++;
            if (g >= 0) begin
                a      = addr[g];
                in_rng = (int'(a) < DEPTH);
                m_err  = !in_rng;
                if (wr[g]) begin
                    if (in_rng) m_mem[a] = wd[g];
                end else begin
                    pq.push_back('{cyc + RD_LAT, g, in_rng ? m_mem[a] : 16'h0});
                end
            end
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        rd = '0;
        wr = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Keep each request asserted until the model says it was granted.
    task automatic serve();
        for (int n = 0; n < 16 && (rd | wr) != 3'b000; n++) begin
            tick();
            if (last_g >= 0) begin
                rd[last_g] = 1'b0;
                wr[last_g] = 1'b0;
            end
        end
        if ((rd | wr) != 3'b000) begin
            n_fail++;
            $display("FAIL serve_bound: requests %b still pending", rd | wr);
        end
    endtask

    task automatic req(input int s, input bit w, input bit r, input logic [3:0] a,
                       input logic [15:0] d);
        wr[s]   = w;
        rd[s]   = r;
        addr[s] = a;
        wd[s]   = d;
    endtask

    task automatic do_reset();
        rd  = '0;
        wr  = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        cyc    = 0;
        known  = 1'b0;
        m_last = 16'h0;
        m_cnt  = 0;
        m_err  = 1'b0;
        rst    = 1'b1;
        rd     = '0;
        wr     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            addr[i] = '0;
            wd[i]   = '0;
        end
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Preload every word so later reads have a known expectation.
        for (int a = 0; a < DEPTH; a++) begin
            req(0, 1'b1, 1'b0, 4'(a), 16'($urandom));
            serve();
        end

        // MAC write then BUS read of the same word.
        req(2, 1'b1, 1'b0, 4'd5, 16'h1234);
        serve();
        req(0, 1'b0, 1'b1, 4'd5, 16'h0);
        serve();
        idle(1);
        chk("t1_read_data", {16'b0, read_data}, 32'h1234);
        idle(2);

        // Three simultaneous reads of preloaded words.
        req(0, 1'b1, 1'b0, 4'd1, 16'h000A); serve();
        req(0, 1'b1, 1'b0, 4'd2, 16'h000B); serve();
        req(0, 1'b1, 1'b0, 4'd3, 16'h000C); serve();
        do_reset();
        req(0, 1'b0, 1'b1, 4'd1, 16'h0);
        req(1, 1'b0, 1'b1, 4'd2, 16'h0);
        req(2, 1'b0, 1'b1, 4'd3, 16'h0);
        serve();
        chk("t2_conflict_cnt", {24'b0, conflict_cnt}, 32'd2);
        idle(3);

        // Read+write from one source: only the write happens.
        req(1, 1'b1, 1'b1, 4'd7, 16'h0055);
        serve();
        idle(3);
        req(1, 1'b0, 1'b1, 4'd7, 16'h0);
        serve();
        idle(3);

        // Out-of-range read.
        req(0, 1'b0, 1'b1, 4'(DEPTH), 16'h0);
        serve();
        idle(3);

        // Reset while a read is in flight; memory survives.
        req(0, 1'b0, 1'b1, 4'd5, 16'h0);
        serve();
        do_reset();
        idle(4);
        req(0, 1'b0, 1'b1, 4'd5, 16'h0);
        serve();
        idle(1);
        chk("t5_read_data", {16'b0, read_data}, 32'h1234);
        idle(2);

        // Random traffic, including out-of-range addresses and mixed read/write.
        for (int n = 0; n < 200; n++) begin
            for (int s = 0; s < N_SRC; s++) begin
                rd[s]   = ($urandom_range(0, 99) < 45);
                wr[s]   = ($urandom_range(0, 99) < 25);
                addr[s] = 4'($urandom_range(0, 15));
                wd[s]   = 16'($urandom);
            end
            tick();
        end
        idle(4);

        // Saturation of the conflict counter.
        do_reset();
        req(0, 1'b0, 1'b1, 4'd0, 16'h0);
        req(2, 1'b0, 1'b1, 4'd1, 16'h0);
        for (int n = 0; n < 300; n++) tick();
        chk("t6_conflict_sat", {24'b0, conflict_cnt}, 32'd255);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
